// File: rtl/rx_phyretrain_responder.sv
// Responder side of the LTSM PHYRETRAIN handshake: answers the partner's START_REQ
// through the shared sideband wrapper and resolves the retrain target state.
module rx_phyretrain_responder #(
    parameter int unsigned SB_MSG_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_phyretrain_en,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_rx_msg_valid,
    input  logic [2:0]              i_rx_msg_info,
    input  logic [2:0]              i_local_msg_info,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_tx_valid,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
    output logic                    o_valid_rx,
    output logic                    o_phyretrain_end_rx,
    output logic [2:0]              o_resolved_state
);

    localparam logic [SB_MSG_WIDTH-1:0] MSG_START_REQ  = SB_MSG_WIDTH'(1);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_START_RESP = SB_MSG_WIDTH'(2);
    localparam logic [2:0] ENC_TXSELFCAL = 3'b001;
    localparam logic [2:0] ENC_SPEEDIDLE = 3'b010;
    localparam logic [2:0] ENC_REPAIR    = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_WAIT_TX_DONE,
        ST_SEND_RESP,
        ST_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              partner_info, partner_info_nxt;
    logic [SB_MSG_WIDTH-1:0] msg_nxt;
    logic                    valid_nxt;
    logic                    end_nxt;
    logic [2:0]              resolved_nxt;
    logic [2:0]              local_norm_c;
    logic [2:0]              partner_norm_c;
    logic [2:0]              resolved_c;
    logic                    start_req_c;

    // Anything that is not a clean one-hot code falls back to SPEEDIDLE.
    function automatic logic [2:0] normalize(input logic [2:0] enc);
        if ((enc != 3'b000) && ((enc & (enc - 3'd1)) == 3'b000)) begin
            return enc;
        end
        return ENC_SPEEDIDLE;
    endfunction

    // Priority SPEEDIDLE > REPAIR > TXSELFCAL across both sides.
    always_comb begin
        local_norm_c   = normalize(i_local_msg_info);
        partner_norm_c = normalize(partner_info);
        if ((local_norm_c == ENC_SPEEDIDLE) || (partner_norm_c == ENC_SPEEDIDLE)) begin
            resolved_c = ENC_SPEEDIDLE;
        end else if ((local_norm_c == ENC_REPAIR) || (partner_norm_c == ENC_REPAIR)) begin
            resolved_c = ENC_REPAIR;
        end else begin
            resolved_c = ENC_TXSELFCAL;
        end
    end

    assign start_req_c = i_rx_msg_valid && (i_decoded_SB_msg == MSG_START_REQ);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= ST_IDLE;
            partner_info        <= 3'b000;
            o_encoded_SB_msg_rx <= '0;
            o_valid_rx          <= 1'b0;
            o_phyretrain_end_rx <= 1'b0;
            o_resolved_state    <= 3'b000;
        end else begin
            state               <= state_nxt;
            partner_info        <= partner_info_nxt;
            o_encoded_SB_msg_rx <= msg_nxt;
            o_valid_rx          <= valid_nxt;
            o_phyretrain_end_rx <= end_nxt;
            o_resolved_state    <= resolved_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        partner_info_nxt = partner_info;
        msg_nxt          = o_encoded_SB_msg_rx;
        valid_nxt        = o_valid_rx;
        end_nxt          = o_phyretrain_end_rx;
        resolved_nxt     = o_resolved_state;

        // Disable wins over every other event and abandons an in-flight response.
        if ((state != ST_IDLE) && !i_phyretrain_en) begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    msg_nxt      = '0;
                    end_nxt      = 1'b0;
                    resolved_nxt = 3'b000;
                    if (i_phyretrain_en) begin
                        state_nxt = ST_WAIT_REQ;
                    end
                end
                ST_WAIT_REQ: begin
                    if (start_req_c) begin
                        partner_info_nxt = i_rx_msg_info;
                        if (i_tx_valid) begin
                            state_nxt = ST_WAIT_TX_DONE;
                        end else begin
                            state_nxt = ST_SEND_RESP;
                            msg_nxt   = MSG_START_RESP;
                            valid_nxt = 1'b1;
                        end
                    end
                end
                ST_WAIT_TX_DONE: begin
                    if (i_falling_edge_busy && i_tx_valid) begin
                        state_nxt = ST_SEND_RESP;
                        msg_nxt   = MSG_START_RESP;
                        valid_nxt = 1'b1;
                    end
                end
                ST_SEND_RESP: begin
                    // A busy edge while TX owns the wrapper is TX's own message.
                    if (i_falling_edge_busy && !i_tx_valid) begin
                        state_nxt    = ST_DONE;
                        valid_nxt    = 1'b0;
                        end_nxt      = 1'b1;
                        resolved_nxt = resolved_c;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_phyretrain_responder.sv
// Randomized self-checking bench for rx_phyretrain_responder; expectations come from
// the handshake sequence the bench drives and a rank-based resolution model.
module tb_rx_phyretrain_responder;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] dec_msg;
    logic         rx_valid;
    logic [2:0]   rx_info;
    logic [2:0]   local_info;
    logic         fbusy;
    logic         tx_valid;
    logic [W-1:0] enc_msg;
    logic         valid_rx;
    logic         end_rx;
    logic [2:0]   resolved;

    int n_tests = 0;
    int n_fail  = 0;

    rx_phyretrain_responder #(.SB_MSG_WIDTH(W)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_phyretrain_en     (en),
        .i_decoded_SB_msg    (dec_msg),
        .i_rx_msg_valid      (rx_valid),
        .i_rx_msg_info       (rx_info),
        .i_local_msg_info    (local_info),
        .i_falling_edge_busy (fbusy),
        .i_tx_valid          (tx_valid),
        .o_encoded_SB_msg_rx (enc_msg),
        .o_valid_rx          (valid_rx),
        .o_phyretrain_end_rx (end_rx),
        .o_resolved_state    (resolved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rank each side (bad codes count as SPEEDIDLE) and keep the higher one.
    function automatic logic [2:0] ref_resolve(input logic [2:0] l, input logic [2:0] p);
        logic [2:0] codes [3];
        int         rank_l, rank_p;
        codes[0] = 3'b001;
        codes[1] = 3'b100;
        codes[2] = 3'b010;
        rank_l = 2;
        rank_p = 2;
        for (int k = 0; k < 3; k++) begin
            if (l == codes[k]) rank_l = k;
            if (p == codes[k]) rank_p = k;
        end
        return codes[(rank_l > rank_p) ? rank_l : rank_p];
    endfunction

    task automatic quiet();
        dec_msg  = '0;
        rx_valid = 1'b0;
        fbusy    = 1'b0;
        tx_valid = 1'b0;
        rx_info  = 3'($urandom_range(0, 7));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid_rx), 32'd0);
        check({tag, "_msg"},   32'(enc_msg),  32'd0);
        check({tag, "_end"},   32'(end_rx),   32'd0);
        check({tag, "_res"},   32'(resolved), 32'd0);
    endtask

    // Drives one handshake from IDLE; ends in DONE unless aborted.
    task automatic handshake(input logic [2:0] rinfo, input logic [2:0] linfo,
                             input bit contend, input bit spur, input bit dup,
                             input bit abort_it);
        en = 1'b1;
        local_info = 3'($urandom_range(0, 7));
        tick();
        check("wait_req_valid", 32'(valid_rx), 32'd0);
        if (spur) begin
            dec_msg = W'(2); rx_valid = 1'b1; rx_info = 3'b100;
            tick();
            check("spur_resp_valid", 32'(valid_rx), 32'd0);
            dec_msg = W'(1); rx_valid = 1'b0;
            tick();
            check("spur_novalid_valid", 32'(valid_rx), 32'd0);
            check("spur_novalid_msg", 32'(enc_msg), 32'd0);
            quiet();
        end
        dec_msg = W'(1); rx_valid = 1'b1; rx_info = rinfo; tx_valid = contend;
        tick();
        quiet();
        if (contend) begin
            tx_valid = 1'b1;
            check("contend_valid", 32'(valid_rx), 32'd0);
            check("contend_msg", 32'(enc_msg), 32'd0);
            fbusy = 1'b1; tx_valid = 1'b0;
            tick();
            check("contend_busy_notx", 32'(valid_rx), 32'd0);
            fbusy = 1'b1; tx_valid = 1'b1;
            tick();
            fbusy = 1'b0; tx_valid = 1'b0;
        end
        check("resp_valid", 32'(valid_rx), 32'd1);
        check("resp_msg", 32'(enc_msg), 32'd2);
        if (abort_it) begin
            en = 1'b0;
            tick();
            check("abort_valid", 32'(valid_rx), 32'd0);
            tick();
            check("abort_msg", 32'(enc_msg), 32'd0);
            check("abort_end", 32'(end_rx), 32'd0);
            return;
        end
        if (dup) begin
            dec_msg = W'(1); rx_valid = 1'b1; rx_info = 3'b010;
            tick();
            quiet();
            check("dup_valid", 32'(valid_rx), 32'd1);
        end
        fbusy = 1'b1; tx_valid = 1'b1;
        tick();
        check("tx_edge_valid", 32'(valid_rx), 32'd1);
        check("tx_edge_end", 32'(end_rx), 32'd0);
        fbusy = 1'b1; tx_valid = 1'b0; local_info = linfo;
        tick();
        quiet();
        local_info = 3'($urandom_range(0, 7));
        check("done_valid", 32'(valid_rx), 32'd0);
        check("done_end", 32'(end_rx), 32'd1);
        check("done_res", 32'(resolved), 32'(ref_resolve(linfo, rinfo)));
        tick();
        check("done_hold_end", 32'(end_rx), 32'd1);
        check("done_hold_res", 32'(resolved), 32'(ref_resolve(linfo, rinfo)));
    endtask

    task automatic teardown();
        en = 1'b0;
        tick();
        check("teardown_end_lvl", 32'(valid_rx), 32'd0);
        tick();
        check_idle_outputs("teardown");
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        local_info = 3'b000;
        quiet();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // Directed cases from the handshake plan.
        handshake(3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0); teardown();
        handshake(3'b100, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0); teardown();
        handshake(3'b010, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0); teardown();
        handshake(3'b011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0); teardown();
        handshake(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); teardown();
        handshake(3'b100, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0); teardown();
        handshake(3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        handshake(3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while in DONE.
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("after_async_reset");
        handshake(3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0); teardown();

        for (int i = 0; i < 60; i++) begin
            logic [2:0] r, l;
            bit         ab;
            r  = 3'($urandom_range(0, 7));
            l  = 3'($urandom_range(0, 7));
            ab = ($urandom_range(0, 7) == 0);
            handshake(r, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ab);
            if (!ab) teardown();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
